multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  7  instruction bits [6:0] from the datapath IR output.
REQ-005 branch_taken  input  1  comparator result from the datapath, valid in EXECUTE.
REQ-006 mem_ready  input  1  memory completion, sampled while mem_req=1.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  store qualifier; 1 only with mem_req in MEM for a store.
REQ-009 addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_we  output  1  IR load enable.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 wb_sel  output  2  write-back source: 00 = ALU, 01 = memory data, 10 = PC+4.
REQ-013 pc_we  output  1  PC load enable.
REQ-014 pc_sel  output  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
REQ-015 halt  output  1  set in HALT state.
REQ-016 illegal  output  1  set in HALT when entered on an unsupported opcode.
REQ-017 instret  output  32  retired-instruction counter.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WB and HALT; all outputs are decoded from the state register and opcode (Moore-style, no dependence on mem_ready except state advance).
REQ-019 FETCH: mem_req=1, addr_sel=0; on mem_ready=1, ir_we=1 in that same cycle and the next state is DECODE; otherwise remain in FETCH with mem_req held.
REQ-020 DECODE: no enables asserted; supported opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111) go to EXECUTE; 1110011 goes to HALT with illegal=0; any other opcode goes to HALT with illegal=1.
REQ-021 EXECUTE, branch (1100011): pc_we=1, pc_sel=01 if branch_taken else 00; instret increments; next FETCH.
REQ-022 EXECUTE, load/store: next MEM, no enables asserted; all other opcodes: next WB.
REQ-023 MEM: mem_req=1, addr_sel=1, mem_we=1 for store; wait on mem_ready; a load goes to WB; a store asserts pc_we=1, pc_sel=00 on the mem_ready cycle, increments instret, then goes to FETCH.
REQ-024 WB: reg_we=1, pc_we=1, instret increments, next FETCH; wb_sel=01 for load, 10 for JAL/JALR, 00 otherwise; pc_sel=01 for JAL, 10 for JALR, 00 otherwise.
REQ-025 Latency with zero-wait memory SHALL be: branch 3 cycles; R/I-type, LUI, AUIPC, JAL, JALR and store 4 cycles; load 5 cycles; each memory wait cycle adds one.
REQ-026 HALT SHALL be absorbing: all enables stay 0 and halt stays 1 until reset.
REQ-027 instret SHALL increment by exactly 1 per retired instruction and wrap from 0xFFFFFFFF to 0.
REQ-028 mem_req SHALL never deassert before mem_ready is seen in FETCH or MEM.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force state=FETCH and instret=0, and drive every registered output to 0, including mid-transaction.
REQ-030 mem_req SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-031 State encoding, opcode constants, and the pc_sel/wb_sel encodings SHALL live in a shared package rv32i_pkg, which is also used by the decode control unit.
REQ-032 The retire counter SHALL be a sub-module, retire_counter, with inputs clk, rst_n and inc, and a 32-bit output count.

Verification
REQ-033 R-type 0x000007B3 with mem_ready tied high: FETCH→DECODE→EXECUTE→WB; reg_we=1, wb_sel=00 in cycle 4; instret=1.
REQ-034 Load with 2 wait cycles in MEM: mem_req held 3 cycles with addr_sel=1; WB has wb_sel=01; total 7 cycles.
REQ-035 Branch with branch_taken=1: pc_we=1, pc_sel=01 in cycle 3; reg_we never asserted.
REQ-036 Opcode 0x7F: HALT after DECODE with halt=1 and illegal=1; no further mem_req for 20 cycles.
REQ-037 Reset pulse during MEM wait: mem_req drops asynchronously; after release, the FSM is in FETCH and instret=0.
REQ-038 instret preloaded (force) to 0xFFFFFFFF, then one JAL retires: instret=0; pc_sel=01, wb_sel=10.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared state, opcode and mux-select encodings for the sequencer
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCS_PC4  = 2'b00;
  localparam logic [1:0] PCS_IMM  = 2'b01;
  localparam logic [1:0] PCS_JALR = 2'b10;

  localparam logic [1:0] WBS_ALU = 2'b00;
  localparam logic [1:0] WBS_MEM = 2'b01;
  localparam logic [1:0] WBS_PC4 = 2'b10;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_supported = 1'b1;
      default:                           is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - free-running 32-bit retired-instruction counter
module retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Natural 32-bit wrap from all-ones back to zero.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 32'd0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle RV32I control FSM with retire counter
module multicycle_sequencer
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   inc;

  logic is_load, is_store, is_branch, is_jal, is_jalr;
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WBS_ALU;
    pc_we     = 1'b0;
    pc_sel    = PCS_PC4;
    halt      = 1'b0;
    illegal   = 1'b0;
    inc       = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_d   = ST_HALT;
          illegal_d = 1'b0;
        end else if (is_supported(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end
      ST_EXECUTE: begin
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PCS_IMM : PCS_PC4;
          inc     = 1'b1;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            inc     = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        inc     = 1'b1;
        wb_sel  = is_load ? WBS_MEM : ((is_jal || is_jalr) ? WBS_PC4 : WBS_ALU);
        pc_sel  = is_jal ? PCS_IMM : (is_jalr ? PCS_JALR : PCS_PC4);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halt    = 1'b1;
        illegal = illegal_q;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset must silence the bus immediately, even mid-transaction.
    if (!rst_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = WBS_ALU;
      pc_we    = 1'b0;
      pc_sel   = PCS_PC4;
      halt     = 1'b0;
      illegal  = 1'b0;
      inc      = 1'b0;
    end
  end

  retire_counter u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, halt, illegal;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  // {mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_sel, halt, illegal}
  localparam logic [11:0] C_FETCH  = 12'h900;
  localparam logic [11:0] C_FWAIT  = 12'h800;
  localparam logic [11:0] C_IDLE   = 12'h000;
  localparam logic [11:0] C_MEM_LD = 12'hA00;
  localparam logic [11:0] C_MEM_ST = 12'hE00;
  localparam logic [11:0] C_ST_RDY = 12'hE10;
  localparam logic [11:0] C_WB_ALU = 12'h090;
  localparam logic [11:0] C_WB_LD  = 12'h0B0;
  localparam logic [11:0] C_WB_JAL = 12'h0D4;
  localparam logic [11:0] C_WB_JR  = 12'h0D8;
  localparam logic [11:0] C_BR_T   = 12'h014;
  localparam logic [11:0] C_BR_NT  = 12'h010;
  localparam logic [11:0] C_HALT   = 12'h002;
  localparam logic [11:0] C_HALT_I = 12'h003;

  logic [11:0] ctl;
  assign ctl = {mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_sel, halt, illegal};

  multicycle_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .halt         (halt),
    .illegal      (illegal),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then check the decoded controls.
  task automatic cyc(input string tag, input logic [6:0] opc, input logic br,
                     input logic rdy, input logic [11:0] exp);
    @(negedge clk);
    opcode       = opc;
    branch_taken = br;
    mem_ready    = rdy;
    #1;
    check(tag, {20'd0, ctl}, {20'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_ctl", {20'd0, ctl}, 32'd0);
    check("rst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_fetch", {20'd0, ctl}, {20'd0, C_FWAIT});
  endtask

  initial begin
    rst_n        = 1'b0;
    opcode       = 7'h00;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // R-type, zero-wait: 4 cycles, one fetch stall first
    cyc("r_fwait", 7'h33, 0, 0, C_FWAIT);
    cyc("r_fetch", 7'h33, 0, 1, C_FETCH);
    cyc("r_dec",   7'h33, 0, 1, C_IDLE);
    cyc("r_exe",   7'h33, 0, 1, C_IDLE);
    cyc("r_wb",    7'h33, 0, 1, C_WB_ALU);

    // Load with 2 wait cycles: 7 cycles total
    cyc("ld_fetch", 7'h03, 0, 1, C_FETCH);
    check("instret_r", instret, 32'd1);
    cyc("ld_dec",   7'h03, 0, 1, C_IDLE);
    cyc("ld_exe",   7'h03, 0, 1, C_IDLE);
    cyc("ld_mem0",  7'h03, 0, 0, C_MEM_LD);
    cyc("ld_mem1",  7'h03, 0, 0, C_MEM_LD);
    cyc("ld_mem2",  7'h03, 0, 1, C_MEM_LD);
    cyc("ld_wb",    7'h03, 0, 1, C_WB_LD);

    // Store, zero-wait: pc_we on the mem_ready cycle
    cyc("st_fetch", 7'h23, 0, 1, C_FETCH);
    check("instret_ld", instret, 32'd2);
    cyc("st_dec",   7'h23, 0, 1, C_IDLE);
    cyc("st_exe",   7'h23, 0, 1, C_IDLE);
    cyc("st_mem",   7'h23, 0, 1, C_ST_RDY);

    // Branch taken then not taken: 3 cycles each, no reg_we
    cyc("bt_fetch", 7'h63, 0, 1, C_FETCH);
    check("instret_st", instret, 32'd3);
    cyc("bt_dec",   7'h63, 1, 1, C_IDLE);
    cyc("bt_exe",   7'h63, 1, 1, C_BR_T);
    cyc("bn_fetch", 7'h63, 0, 1, C_FETCH);
    check("instret_bt", instret, 32'd4);
    cyc("bn_dec",   7'h63, 0, 1, C_IDLE);
    cyc("bn_exe",   7'h63, 0, 1, C_BR_NT);

    // JALR
    cyc("jr_fetch", 7'h67, 0, 1, C_FETCH);
    check("instret_bn", instret, 32'd5);
    cyc("jr_dec",   7'h67, 0, 1, C_IDLE);
    cyc("jr_exe",   7'h67, 0, 1, C_IDLE);
    cyc("jr_wb",    7'h67, 0, 1, C_WB_JR);

    // Reset pulse during a MEM wait
    cyc("rl_fetch", 7'h03, 0, 1, C_FETCH);
    check("instret_jr", instret, 32'd6);
    cyc("rl_dec",   7'h03, 0, 1, C_IDLE);
    cyc("rl_exe",   7'h03, 0, 1, C_IDLE);
    cyc("rl_mem",   7'h03, 0, 0, C_MEM_LD);
    rst_n = 1'b0;
    #1;
    check("async_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rl_back_fetch", {20'd0, ctl}, {20'd0, C_FWAIT});

    // instret wrap on a JAL
    force dut.u_retire.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_retire.count_q;
    #1;
    check("preload", instret, 32'hFFFF_FFFF);
    cyc("jal_fetch", 7'h6F, 0, 1, C_FETCH);
    cyc("jal_dec",   7'h6F, 0, 1, C_IDLE);
    cyc("jal_exe",   7'h6F, 0, 1, C_IDLE);
    cyc("jal_wb",    7'h6F, 0, 1, C_WB_JAL);
    cyc("after_jal", 7'h6F, 0, 0, C_FWAIT);
    check("instret_wrap", instret, 32'd0);

    // SYSTEM halts without illegal
    cyc("sys_fetch", 7'h73, 0, 1, C_FETCH);
    cyc("sys_dec",   7'h73, 0, 1, C_IDLE);
    cyc("sys_halt",  7'h73, 0, 1, C_HALT);

    // Unsupported opcode halts with illegal and stays absorbed
    do_reset();
    cyc("ill_fetch", 7'h7F, 0, 1, C_FETCH);
    cyc("ill_dec",   7'h7F, 0, 1, C_IDLE);
    for (int i = 0; i < 20; i++) begin
      cyc("ill_halt", (i % 2 == 0) ? 7'h33 : 7'h7F, 1'(i % 3 == 0), 1'(i % 2), C_HALT_I);
    end
    check("halt_instret", instret, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
